// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register for the 5-stage CPU, with load-use hazard
// detection. It captures the decoded control word, operands and register
// fields from ID and presents them to EX one cycle later. If the instruction
// in EX is a load whose destination (rt) is a source of the instruction in ID,
// PC and IF/ID are frozen for one cycle and a bubble is written into EX. A
// branch/jump flush also writes a bubble. hold_i freezes all state.
//
// Control word packing (id_ctrl_i / ex_ctrl_o, bit 14 down to bit 0):
//   {RegWrite, ALUOp[2:0], ALUSrc, RegDst[1:0], MemtoReg[1:0],
//    Branch, BranchType, Jump, MemRead, MemWrite, Jal}
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   hold_i                global freeze; every register holds
//   flush_i               next EX slot becomes a bubble
//   id_*_i                control word, PC+4, operands, immediate, funct and
//                         rs/rt/rd fields of the instruction in ID
//   ex_*_o                registered copies of the above for EX
//   ex_valid_o            1 = EX holds a real instruction, 0 = bubble
//   pc_write_o            0 = PC must hold this cycle
//   ifid_write_o          0 = IF/ID register must hold this cycle
//   stall_cnt_o           saturating load-use stall count
//
// Configuration
//   IDEX_STALL_CNT_EN     when defined, builds a 16-bit saturating counter of
//                         load-use stall cycles on stall_cnt_o; when undefined
//                         stall_cnt_o is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [14:0]       id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [5:0]        id_funct_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic [14:0]       ex_ctrl_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [5:0]        ex_funct_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [15:0]       stall_cnt_o
);

  localparam int MEMREAD_BIT = 2;

  logic [14:0]       ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] pc4_q,     pc4_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [5:0]        funct_q,   funct_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              valid_q,   valid_d;
  logic              luh;

  // Hazard detection: a valid load in EX writing a non-zero rt that the ID
  // instruction reads. $0 is excluded because it never carries loaded data.
  always_comb begin
    luh = valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != '0) &
          ((rt_q == id_rs_i) | (rt_q == id_rt_i));
  end

  // flush_i is deliberately absent here: the redirect is handled in IF.
  assign pc_write_o   = ~(luh | hold_i);
  assign ifid_write_o = ~(luh | hold_i);

  // Next-state selection: hold > flush > load-use bubble > load.
  // A bubble clears data and register fields too, so forwarding compares
  // against EX can never match a stale register number.
  always_comb begin
    ctrl_d    = ctrl_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    funct_d   = funct_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    if (hold_i) begin
      // keep everything
    end else if (flush_i || luh) begin
      ctrl_d    = '0;
      pc4_d     = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      funct_d   = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      valid_d   = 1'b0;
    end else begin
      ctrl_d    = id_ctrl_i;
      pc4_d     = id_pc4_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      funct_d   = id_funct_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
      valid_d   = 1'b1;
    end
  end

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      funct_q   <= funct_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
    end
  end

  assign ex_ctrl_o    = ctrl_q;
  assign ex_pc4_o     = pc4_q;
  assign ex_rs_data_o = rs_data_q;
  assign ex_rt_data_o = rt_data_q;
  assign ex_imm_o     = imm_q;
  assign ex_funct_o   = funct_q;
  assign ex_rs_o      = rs_q;
  assign ex_rt_o      = rt_q;
  assign ex_rd_o      = rd_q;
  assign ex_valid_o   = valid_q;

`ifdef IDEX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts only edges where the load-use bubble actually takes effect;
  // a coincident flush or hold means no stall cycle was spent on it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (luh && !hold_i && !flush_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [14:0] LW_CTRL  = 15'h4444; // RegWrite,ALUSrc,MemtoReg=01,MemRead
  localparam logic [14:0] ADD_CTRL = 15'h5100; // RegWrite,ALUOp=010,RegDst=01

  logic              clk = 1'b0;
  logic              rst, hold, flush;
  logic [14:0]       id_ctrl;
  logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [14:0]       ex_ctrl;
  logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]        ex_funct;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic              ex_valid, pc_write, ifid_write;
  logic [15:0]       stall_cnt;

  id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_ctrl_i(id_ctrl), .id_pc4_i(id_pc4), .id_rs_data_i(id_rs_data),
    .id_rt_data_i(id_rt_data), .id_imm_i(id_imm), .id_funct_i(id_funct),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .ex_ctrl_o(ex_ctrl), .ex_pc4_o(ex_pc4), .ex_rs_data_o(ex_rs_data),
    .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm), .ex_funct_o(ex_funct),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_valid_o(ex_valid), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the instruction currently sitting in EX, as a record.
  typedef struct packed {
    logic [14:0]       ctrl;
    logic [DATA_W-1:0] pc4, rs_data, rt_data, imm;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              valid;
  } slot_t;

  slot_t m_ex = '0;
  int    m_cnt = 0;
  logic  exp_pcw, pcw_s, ifidw_s;

  function automatic bit model_luh();
    return m_ex.valid && m_ex.ctrl[2] && (m_ex.rt != 0) &&
           ((m_ex.rt == id_rs) || (m_ex.rt == id_rt));
  endfunction

  function automatic slot_t id_slot();
    slot_t s;
    s = '{ctrl: id_ctrl, pc4: id_pc4, rs_data: id_rs_data, rt_data: id_rt_data,
           imm: id_imm, funct: id_funct, rs: id_rs, rt: id_rt, rd: id_rd, valid: 1'b1};
    return s;
  endfunction

  function automatic slot_t dut_slot();
    slot_t s;
    s = '{ctrl: ex_ctrl, pc4: ex_pc4, rs_data: ex_rs_data, rt_data: ex_rt_data,
           imm: ex_imm, funct: ex_funct, rs: ex_rs, rt: ex_rt, rd: ex_rd, valid: ex_valid};
    return s;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef IDEX_STALL_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // Samples the stall outputs mid-cycle, advances one edge, updates the model.
  task automatic tick();
    bit l;
    @(negedge clk);
    l       = model_luh();
    exp_pcw = !(l || hold);
    pcw_s   = pc_write;
    ifidw_s = ifid_write;
    @(posedge clk);
    if (rst) begin
      m_ex  = '0;
      m_cnt = 0;
    end else if (hold) begin
      // frozen
    end else if (flush || l) begin
      if (l && !flush && m_cnt < 65535) m_cnt++;
      m_ex = '0;
    end else begin
      m_ex = id_slot();
    end
    #1;
  endtask

  task automatic rand_data();
    id_pc4     = $urandom;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_funct   = 6'($urandom);
    id_rd      = REG_AW'($urandom);
  endtask

  task automatic set_id(input logic [14:0] c, input int rs_, input int rt_);
    rand_data();
    id_ctrl = c;
    id_rs   = REG_AW'(rs_);
    id_rt   = REG_AW'(rt_);
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(ADD_CTRL, 1, 2);
    tick();
    tick();
    n_vec++;
    if ({ex_ctrl, ex_valid, ex_pc4, ex_imm, ex_rt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ctrl=%h valid=%b pc4=%h imm=%h rt=%0d, want all 0",
               ex_ctrl, ex_valid, ex_pc4, ex_imm, ex_rt);
    end
    n_vec++;
    if ({pc_write, ifid_write} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_write_en: pc_write=%b ifid_write=%b, want 1 1", pc_write, ifid_write);
    end
    n_vec++;
    if (stall_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_cnt: got %h want 0000", stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    set_id(15'h4A00, 3, 4);
    id_imm = 32'h0000_0010;
    tick();
    n_vec++;
    if (ex_ctrl !== 15'h4A00 || ex_imm !== 32'h10 || ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pass_through: ctrl=%h imm=%h valid=%b, want 4a00 00000010 1",
               ex_ctrl, ex_imm, ex_valid);
    end
    n_vec++;
    if (dut_slot() !== m_ex) begin
      n_err++;
      $display("FAIL pass_through_fields: got %h want %h", dut_slot(), m_ex);
    end
  endtask

  task automatic test_load_use();
    set_id(LW_CTRL, 1, 8);
    tick();                      // lw now in EX
    set_id(ADD_CTRL, 8, 9);      // reads $8
    tick();                      // bubble edge
    n_vec++;
    if ({pcw_s, ifidw_s} !== 2'b00) begin
      n_err++;
      $display("FAIL load_use_stall: pc_write=%b ifid_write=%b, want 0 0", pcw_s, ifidw_s);
    end
    n_vec++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'h0 || ex_rt !== '0) begin
      n_err++;
      $display("FAIL load_use_bubble: valid=%b ctrl=%h rt=%0d, want 0 0 0", ex_valid, ex_ctrl, ex_rt);
    end
    tick();                      // ID instruction advances
    n_vec++;
    if (pcw_s !== 1'b1 || ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL || ex_rs !== 5'd8) begin
      n_err++;
      $display("FAIL load_use_release: pc_write=%b valid=%b ctrl=%h rs=%0d, want 1 1 %h 8",
               pcw_s, ex_valid, ex_ctrl, ex_rs, ADD_CTRL);
    end
    n_vec++;
    if (stall_cnt !== exp_cnt()) begin
      n_err++;
      $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt());
    end
  endtask

  task automatic test_load_zero();
    set_id(LW_CTRL, 2, 0);
    tick();
    set_id(ADD_CTRL, 0, 0);
    tick();
    n_vec++;
    if (pcw_s !== 1'b1 || ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL) begin
      n_err++;
      $display("FAIL load_zero: pc_write=%b valid=%b ctrl=%h, want 1 1 %h",
               pcw_s, ex_valid, ex_ctrl, ADD_CTRL);
    end
  endtask

  task automatic test_flush();
    set_id(ADD_CTRL, 1, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 15'h0 || pcw_s !== 1'b1) begin
      n_err++;
      $display("FAIL flush: valid=%b ctrl=%h pc_write=%b, want 0 0 1", ex_valid, ex_ctrl, pcw_s);
    end
    // flush coincident with a load-use hazard
    set_id(LW_CTRL, 1, 5);
    tick();
    set_id(ADD_CTRL, 5, 6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (pcw_s !== 1'b0 || ex_valid !== 1'b0 || ex_ctrl !== 15'h0) begin
      n_err++;
      $display("FAIL flush_luh: pc_write=%b valid=%b ctrl=%h, want 0 0 0", pcw_s, ex_valid, ex_ctrl);
    end
    n_vec++;
    if (stall_cnt !== exp_cnt()) begin
      n_err++;
      $display("FAIL flush_luh_cnt: got %0d want %0d", stall_cnt, exp_cnt());
    end
  endtask

  task automatic test_hold();
    slot_t held;
    set_id(ADD_CTRL, 10, 11);
    tick();
    held = m_ex;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(15'($urandom), i, i + 12);
      tick();
      n_vec++;
      if (dut_slot() !== held || pcw_s !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: ex=%h pc_write=%b, want ex=%h pc_write=0", i, dut_slot(), pcw_s, held);
      end
    end
    hold = 1'b0;
    set_id(15'h0A11, 13, 14);
    tick();
    n_vec++;
    if (dut_slot() !== m_ex || ex_ctrl !== 15'h0A11 || ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: got %h want %h", dut_slot(), m_ex);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(LW_CTRL, 1, 7);
    tick();
    set_id(ADD_CTRL, 7, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ex_valid !== 1'b0 || stall_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_stall: pc_write=%b ifid_write=%b valid=%b cnt=%0d, want 1 1 0 0",
               pc_write, ifid_write, ex_valid, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_ctrl = 15'($urandom);
      rand_data();
      id_rs = REG_AW'($urandom_range(0, 3));
      id_rt = REG_AW'($urandom_range(0, 3));
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
      n_vec++;
      if (dut_slot() !== m_ex || pcw_s !== exp_pcw || ifidw_s !== exp_pcw ||
          stall_cnt !== exp_cnt()) begin
        n_err++;
        $display("FAIL random_%0d: ex=%h pcw=%b ifidw=%b cnt=%0d, want ex=%h pcw=%b cnt=%0d",
                 i, dut_slot(), pcw_s, ifidw_s, stall_cnt, m_ex, exp_pcw, exp_cnt());
      end
    end
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_ctrl = '0; id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_funct = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_load_zero();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
